// File: rtl/adder_pkg.sv
// Shared types for the sequential accumulator:
// FSM state encoding and the add/subtract mode constants.
package adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/carry_lookahead_adder.sv
// WIDTH-bit carry-lookahead adder with carry-out and
// two's-complement overflow.
module carry_lookahead_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH:0]   w_c;
  logic             w_pp;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Each carry is expanded from generate/propagate terms
  // rather than chained from the previous carry.
  always_comb begin
    w_c    = '0;
    w_pp   = 1'b0;
    w_c[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      w_c[i+1] = w_g[i];
      w_pp     = w_p[i];
      for (int j = i - 1; j >= 0; j--) begin
        w_c[i+1] = w_c[i+1] | (w_pp & w_g[j]);
        w_pp     = w_pp & w_p[j];
      end
      w_c[i+1] = w_c[i+1] | (w_pp & cin);
    end
  end

  assign sum  = w_p ^ w_c[WIDTH-1:0];
  assign cout = w_c[WIDTH];
  assign ovf  = w_c[WIDTH] ^ w_c[WIDTH-1];

endmodule

// File: rtl/sequential_accumulator.sv
// Accumulates OPERANDS values over a valid/ready stream,
// adding or subtracting, with sticky carry/borrow and overflow.
module sequential_accumulator
  import adder_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int OPERANDS = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic             carry_in,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(OPERANDS);

  state_t           r_state;
  state_t           w_next;
  logic             r_mode;
  logic             r_cin;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_result;
  logic             r_sc;
  logic             r_sv;
  logic             r_carry;
  logic             r_ovf;

  logic             w_hs;
  logic             w_first;
  logic             w_last;
  logic [WIDTH-1:0] w_b;
  logic             w_cin;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_ovf;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_step_c;
  logic             w_step_v;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next = S_ACCUM;
      end
      S_ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && w_last) w_next = S_DONE;
      end
      S_DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_hs    = in_valid & in_ready;
  assign w_first = (r_cnt == '0);
  assign w_last  = (r_cnt == CW'(OPERANDS - 1));

  // Subtract is acc + ~x + 1; carry_in only feeds the first add step.
  assign w_b   = (r_mode == MODE_SUB) ? ~in_data : in_data;
  assign w_cin = (r_mode == MODE_SUB) ? 1'b1
               : (r_cnt == CW'(1)) & r_cin;

  carry_lookahead_adder #(
    .WIDTH(WIDTH)
  ) u_cla (
    .a   (r_acc),
    .b   (w_b),
    .cin (w_cin),
    .sum (w_sum),
    .cout(w_cout),
    .ovf (w_ovf)
  );

  assign w_acc_next = w_first ? in_data : w_sum;
  assign w_step_c   = ~w_first &
                      ((r_mode == MODE_SUB) ? ~w_cout : w_cout);
  assign w_step_v   = ~w_first & w_ovf;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mode   <= MODE_ADD;
      r_cin    <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_sc     <= 1'b0;
      r_sv     <= 1'b0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_mode <= mode;
        r_cin  <= carry_in;
        r_cnt  <= '0;
        r_sc   <= 1'b0;
        r_sv   <= 1'b0;
      end
      if (w_hs) begin
        r_acc <= w_acc_next;
        r_sc  <= r_sc | w_step_c;
        r_sv  <= r_sv | w_step_v;
        r_cnt <= w_last ? '0 : r_cnt + CW'(1);
        // Outputs load here so they are valid during the done pulse.
        if (w_last) begin
          r_result <= w_acc_next;
          r_carry  <= r_sc | w_step_c;
          r_ovf    <= r_sv | w_step_v;
        end
      end
    end
  end

  assign result    = r_result;
  assign carry_out = r_carry;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_sequential_accumulator.sv
// Directed bench for sequential_accumulator with a
// done-driven scoreboard monitor.
module tb_sequential_accumulator;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       mode;
  logic       carry_in;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] result;
  logic       carry_out;
  logic       overflow;
  logic       busy;
  logic       done;

  typedef struct {
    logic [7:0] res;
    logic       c;
    logic       v;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  sequential_accumulator #(
    .WIDTH(8),
    .OPERANDS(4)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .mode     (mode),
    .carry_in (carry_in),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .result   (result),
    .carry_out(carry_out),
    .overflow (overflow),
    .busy     (busy),
    .done     (done)
  );

  always #5 clock = ~clock;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        chk("spurious_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result", 32'(result), 32'(e.res));
        chk("carry_out", 32'(carry_out), 32'(e.c));
        chk("overflow", 32'(overflow), 32'(e.v));
      end
    end
  end

  task automatic run(input logic m, input logic ci,
                     input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] c, input logic [7:0] d,
                     input int gap, input bit glitch,
                     input logic [7:0] er, input logic ec,
                     input logic ev);
    logic [7:0] ops[4];
    ops = '{a, b, c, d};
    @(negedge clock);
    chk("idle_ready", 32'(in_ready), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    start = 1'b1; mode = m; carry_in = ci;
    @(negedge clock);
    start = 1'b0; mode = ~m; carry_in = ~ci;
    chk("accum_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        repeat (gap) begin
          @(negedge clock);
          chk("gap_ready", 32'(in_ready), 32'd1);
        end
      end
      @(negedge clock);
      chk("hs_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_data  = ops[k];
      if (glitch && k == 1) begin
        start = 1'b1; mode = 1'b1; carry_in = 1'b1;
      end
      @(posedge clock);
      #1;
      start = 1'b0;
      if (k == 3) q.push_back('{er, ec, ev});
      in_valid = 1'b0;
      in_data  = 8'hFF;
    end
    @(negedge clock);
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd1);
    chk("done_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    @(negedge clock);
    chk("post_done", 32'(done), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; mode = 1'b0; carry_in = 1'b0;
    in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge clock);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b0;

    run(1'b0, 1'b1, 8'd10, 8'd20, 8'd30, 8'd40, 0, 0,
        8'd101, 1'b0, 1'b0);
    run(1'b0, 1'b0, 8'd200, 8'd100, 8'd0, 8'd0, 0, 0,
        8'd44, 1'b1, 1'b0);
    run(1'b0, 1'b0, 8'd100, 8'd100, 8'd0, 8'd0, 0, 0,
        8'd200, 1'b0, 1'b1);
    run(1'b1, 1'b1, 8'd50, 8'd20, 8'd10, 8'd5, 0, 0,
        8'd15, 1'b0, 1'b0);
    run(1'b1, 1'b0, 8'd5, 8'd10, 8'd0, 8'd0, 0, 0,
        8'd251, 1'b1, 1'b0);
    run(1'b1, 1'b0, 8'd100, 8'd156, 8'd0, 8'd0, 0, 0,
        8'd200, 1'b1, 1'b1);
    run(1'b0, 1'b0, 8'd1, 8'd2, 8'd3, 8'd4, 3, 0,
        8'd10, 1'b0, 1'b0);

    // Abort after two handshakes: reset clears held results too.
    @(negedge clock);
    start = 1'b1; mode = 1'b0; carry_in = 1'b0;
    @(negedge clock);
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_data = 8'd9;
      @(negedge clock);
    end
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_carry", 32'(carry_out), 32'd0);
    chk("abort_ovf", 32'(overflow), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(in_ready), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    in_valid = 1'b1; in_data = 8'd7;
    repeat (3) begin
      @(negedge clock);
      chk("wait_start_ready", 32'(in_ready), 32'd0);
      chk("wait_start_busy", 32'(busy), 32'd0);
    end
    in_valid = 1'b0;
    run(1'b0, 1'b0, 8'd1, 8'd1, 8'd1, 8'd1, 0, 0,
        8'd4, 1'b0, 1'b0);

    run(1'b0, 1'b0, 8'd1, 8'd2, 8'd3, 8'd4, 1, 1,
        8'd10, 1'b0, 1'b0);

    repeat (4) @(negedge clock);
    chk("pending_expect", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sequential_accumulator.md
SEQUENTIAL_ACCUMULATOR -- requirements
Module: sequential_accumulator

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter: WIDTH, 8, operand/result width in bits (legal 2..32).
REQ-003 Parameter: OPERANDS, 4, operands per accumulation (legal 2..16).
REQ-004 Port: clock  input  1  system clock; all state changes on its rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-high; clears all state.
REQ-006 Port: start  input  1  begins an accumulation when the FSM is in IDLE.
REQ-007 Port: mode  input  1  0 = add, 1 = subtract; sampled with start.
REQ-008 Port: carry_in  input  1  carry into the first add step (add mode only); sampled with start.
REQ-009 Port: in_valid  input  1  in_data holds an operand.
REQ-010 Port: in_data  input  WIDTH  operand value.
REQ-011 Port: in_ready  output  1  block accepts an operand this cycle.
REQ-012 Port: result  output  WIDTH  final accumulated value.
REQ-013 Port: carry_out  output  1  sticky carry (add mode) or sticky borrow (subtract mode).
REQ-014 Port: overflow  output  1  sticky two's-complement overflow.
REQ-015 Port: busy  output  1  accumulation in progress.
REQ-016 Port: done  output  1  one-cycle pulse; result and flags are valid.

Function
REQ-017 FSM states SHALL be IDLE, ACCUM and DONE.
REQ-018 IDLE -> ACCUM on start=1: latch mode and carry_in; clear the operand counter, carry_out and overflow.
REQ-019 ACCUM: in_ready=1; a handshake is in_valid & in_ready; while in_valid=0, state holds.
REQ-020 Operand 0 handshake: acc <= in_data, with no adder step.
REQ-021 Operand k>0, add mode: acc <= acc + in_data + c, where c = latched carry_in for k=1 and 0 otherwise.
REQ-022 Operand k>0, subtract mode: acc <= acc + ~in_data + 1; latched carry_in is ignored.
REQ-023 Each adder step SHALL OR into the sticky flags: carry_out |= cout (add) or |= ~cout (subtract); overflow |= signed overflow of that step.
REQ-024 All arithmetic is modulo 2^WIDTH; bits beyond WIDTH are discarded.
REQ-025 The handshake of operand OPERANDS-1 SHALL move the FSM to DONE; the counter returns to 0.
REQ-026 DONE lasts exactly one cycle: done=1, result updated from acc; next state is IDLE.
REQ-027 Latency: done SHALL be asserted on the cycle after the last handshake.
REQ-028 result, carry_out and overflow SHALL hold their values until the next DONE or reset.
REQ-029 in_ready SHALL be 0 in IDLE and DONE; in_valid in those states is ignored.
REQ-030 start in ACCUM or DONE SHALL be ignored; mode and carry_in are not re-sampled.
REQ-031 busy SHALL be 1 in ACCUM and DONE, and 0 in IDLE.

Reset
REQ-032 On reset the FSM SHALL enter IDLE; acc, counter, result, carry_out, overflow, done, busy and in_ready are 0.
REQ-033 Reset asserted mid-accumulation SHALL abort the operation without a done pulse; after release, the block waits for a new start.

Structure
REQ-034 The FSM state encoding and the mode constants (ADD=0, SUB=1) SHALL live in the shared package adder_pkg.
REQ-035 Each adder step SHALL use one instance of the existing carry_lookahead_adder at WIDTH; no other sub-modules.

Verification
REQ-036 Add, WIDTH=8, OPERANDS=4, carry_in=1, operands 10,20,30,40 back-to-back -> result=101, carry_out=0, overflow=0, done 1 cycle after the 4th handshake.
REQ-037 Add 200,100,0,0 -> result=44, carry_out=1, overflow=0; add 100,100,0,0 -> result=200, carry_out=0, overflow=1.
REQ-038 Subtract 50,20,10,5 -> result=15, carry_out=0; subtract 5,10,0,0 -> result=251, carry_out=1 (borrow).
REQ-039 Add 1,2,3,4 with in_valid low for 3 cycles between operands -> result=10; in_ready stays 1 throughout ACCUM; no extra acceptances.
REQ-040 Reset after 2 handshakes -> all outputs 0, no done pulse; a new start with 1,1,1,1 -> result=4.
REQ-041 Pulse start during ACCUM with mode=1 -> ignored; the add result is unchanged and only one done pulse occurs.
